// File: rtl/ins_fetch_queue_pkg.sv
// ins_fetch_queue_pkg: opcodes, immediate decoders and FSM states for the fetch/queue stage.
package ins_fetch_queue_pkg;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic {S_RUN, S_DISCARD} state_t;
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/ins_fetch_queue_fifo.sv
// iq_fifo: circular buffer with head/tail/count, push, pop and synchronous clear.
module iq_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  assign dout = count != 0 ? mem[head] : '0;
  always_ff @(posedge clk)
    if (push) mem[tail] <= din;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/ins_fetch_queue.sv
// ins_fetch_queue: PC generation, icache fetch, BHT-steered next-PC and dispatch FIFO.
// BHT_PREDICT_EN: when defined, branches follow bht_get; otherwise branches are predicted not-taken.
module ins_fetch_queue
  import ins_fetch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int BHT_IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  output logic                 icache_req_valid,
  output logic [31:0]          icache_addr,
  input  logic                 icache_ready,
  input  logic [31:0]          icache_data,
  output logic [BHT_IDX_W-1:0] bht_id,
  input  logic                 bht_get,
  output logic                 iq_out_valid,
  output logic [31:0]          iq_out_ins,
  output logic [31:0]          iq_out_pc,
  output logic                 iq_out_pred,
  output logic [BHT_IDX_W-1:0] iq_out_bht_id,
  input  logic                 iq_out_ready,
  input  logic                 rob_flush,
  input  logic [31:0]          rob_flush_pc
);
  localparam int EW = 65 + BHT_IDX_W;
  state_t state;
  logic [31:0] pc, next_pc;
  logic [$clog2(QUEUE_DEPTH):0] count;
  logic [BHT_IDX_W-1:0] idx;
  logic [EW-1:0] dout;
  logic is_jal, is_br, br_taken, pred, fire, pop, clear;
  assign idx = pc[BHT_IDX_W+1:2];
  assign icache_addr = pc;
  assign icache_req_valid = state == S_RUN && count < QUEUE_DEPTH;
`ifdef BHT_PREDICT_EN
  assign bht_id = idx;
  assign br_taken = bht_get;
`else
  logic unused;
  assign unused = bht_get;
  assign bht_id = '0;
  assign br_taken = 1'b0;
`endif
  assign is_jal = icache_data[6:0] == OP_JAL;
  assign is_br = icache_data[6:0] == OP_BRANCH;
  assign pred = is_jal || (is_br && br_taken);
  assign next_pc = pc + (is_jal ? imm_j(icache_data) : pred ? imm_b(icache_data) : 32'd4);
  assign fire = rdy && !rob_flush && icache_ready && icache_req_valid;
  assign pop = rdy && !rob_flush && iq_out_valid && iq_out_ready;
  assign clear = rdy && rob_flush;
  assign iq_out_valid = count != 0;
  assign {iq_out_ins, iq_out_pc, iq_out_pred, iq_out_bht_id} = dout;
  iq_fifo #(.DEPTH(QUEUE_DEPTH), .W(EW)) fifo (
    .clk(clk), .rst(rst), .push(fire), .pop(pop), .clear(clear),
    .din({icache_data, pc, pred, idx}), .dout(dout), .count(count)
  );
  // A flush with a request in flight must swallow that request's late response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      pc <= '0;
    end else if (rdy) begin
      if (rob_flush) pc <= rob_flush_pc;
      else if (fire) pc <= next_pc;
      state <= state == S_DISCARD ? (icache_ready ? S_RUN : S_DISCARD)
             : (rob_flush && icache_req_valid && !icache_ready ? S_DISCARD : S_RUN);
    end
  end
endmodule

// File: tb/tb_ins_fetch_queue.sv
// tb_ins_fetch_queue: random icache/dispatch/flush traffic checked against a queue-based reference model.
module tb_ins_fetch_queue;
  localparam int DEPTH = 16;
`ifdef BHT_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, rdy = 0, icache_ready = 0, bht_get = 0, iq_out_ready = 0, rob_flush = 0;
  logic [31:0] icache_data = 0, rob_flush_pc = 0;
  logic icache_req_valid, iq_out_valid, iq_out_pred;
  logic [31:0] icache_addr, iq_out_ins, iq_out_pc;
  logic [7:0] bht_id, iq_out_bht_id;

  ins_fetch_queue #(.QUEUE_DEPTH(DEPTH), .BHT_IDX_W(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .icache_req_valid(icache_req_valid), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data(icache_data), .bht_id(bht_id), .bht_get(bht_get),
    .iq_out_valid(iq_out_valid), .iq_out_ins(iq_out_ins), .iq_out_pc(iq_out_pc), .iq_out_pred(iq_out_pred),
    .iq_out_bht_id(iq_out_bht_id), .iq_out_ready(iq_out_ready), .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] ins; logic [31:0] pc; logic pred; logic [7:0] idx;} ent_t;
  ent_t exp_q[$];
  logic [31:0] script[$] = '{32'h13, 32'h13, 32'h13, 32'h13, 32'h00000463, 32'h13, 32'h13, 32'h0100006F};
  int checks = 0, errors = 0, pops = 0;
  logic [31:0] mpc = 0;
  int mcount = 0;
  bit mdisc = 0, outst = 0;
  int lat = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int j_off(logic [31:0] w);
    return (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
  endfunction
  function automatic int b_off(logic [31:0] w);
    return (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
  endfunction

  // Reference model: fetch PC, discard flag and expected FIFO contents.
  always @(posedge clk) begin
    bit req, popm;
    ent_t e;
    if (!rst && rdy) begin
      req = !mdisc && mcount < DEPTH;
      popm = mcount > 0 && iq_out_ready;
      if (rob_flush) begin
        mdisc = mdisc ? !icache_ready : (req && !icache_ready);
        mpc = rob_flush_pc;
        mcount = 0;
        exp_q.delete();
      end else if (mdisc) begin
        if (icache_ready) mdisc = 0;
      end else begin
        if (req && icache_ready) begin
          e.ins = icache_data;
          e.pc = mpc;
          e.idx = mpc[9:2];
          if (icache_data[6:0] == 7'h6F) begin
            e.pred = 1;
            mpc = mpc + j_off(icache_data);
          end else if (icache_data[6:0] == 7'h63 && PRED_EN && bht_get) begin
            e.pred = 1;
            mpc = mpc + b_off(icache_data);
          end else begin
            e.pred = 0;
            mpc = mpc + 4;
          end
          exp_q.push_back(e);
          mcount++;
        end
        if (popm) mcount--;
      end
    end
  end

  // Monitor: checks request side every cycle and pops the scoreboard on each dispatch handshake.
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      chk("valid", iq_out_valid, 32'(mcount != 0));
      chk("req_valid", icache_req_valid, 32'(!mdisc && mcount < DEPTH));
      if (!mdisc && mcount < DEPTH) begin
        chk("addr", icache_addr, mpc);
        chk("bht_id", bht_id, PRED_EN ? 32'(mpc[9:2]) : 32'd0);
      end
      if (rdy && !rob_flush && iq_out_valid && iq_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty actual=valid required=empty t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ins", iq_out_ins, e.ins);
          chk("pc", iq_out_pc, e.pc);
          chk("pred", iq_out_pred, 32'(e.pred));
          chk("q_bht_id", iq_out_bht_id, 32'(e.idx));
          pops++;
        end
      end
    end
  end

  function automatic logic [31:0] next_ins();
    logic [31:0] r = $urandom;
    if (script.size() != 0) return script.pop_front();
    case ($urandom_range(7))
      0: return 32'h13;
      1: return 32'h00000463;
      2: return 32'h0100006F;
      3: return 32'hFFDFF06F;
      4: return 32'h000080E7;
      5: return {r[31:7], 7'h63};
      6: return {r[31:7], 7'h6F};
      default: return r;
    endcase
  endfunction

  task automatic step(int p_rdy, int p_ordy, int p_flush);
    logic [31:0] r;
    @(posedge clk);
    #1;
    if (icache_ready && rdy) outst = 0;
    rdy = $urandom_range(99) < p_rdy;
    iq_out_ready = $urandom_range(99) < p_ordy;
    bht_get = $urandom_range(1);
    if (!outst && icache_req_valid) begin
      outst = 1;
      lat = $urandom_range(2);
    end
    icache_ready = outst && lat == 0;
    if (outst && lat > 0) lat--;
    icache_data = icache_ready ? next_ins() : $urandom;
    rob_flush = $urandom_range(99) < p_flush && !(mdisc && icache_ready);
    r = $urandom;
    case ($urandom_range(2))
      0: rob_flush_pc = 32'h0;
      1: rob_flush_pc = 32'h200;
      default: rob_flush_pc = {r[31:2], 2'b00};
    endcase
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", iq_out_valid, 0);
    chk("rst_ins", iq_out_ins, 0);
    chk("rst_pc", iq_out_pc, 0);
    chk("rst_pred", iq_out_pred, 0);
    chk("rst_bht", iq_out_bht_id, 0);
    chk("rst_addr", icache_addr, 0);
    rst = 0;
    rdy = 1;
    repeat (70) step(100, 0, 0);
    #2;
    chk("full_req", icache_req_valid, 0);
    chk("full_valid", iq_out_valid, 1);
    step(100, 100, 0);
    repeat (10) step(100, 0, 0);
    step(100, 100, 0);
    step(100, 0, 0);
    step(100, 0, 100);
    repeat (10) step(100, 50, 0);
    repeat (3) step(0, 100, 0);
    repeat (3000) step(85, 60, 3);
    step(100, 0, 0);
    rob_flush = 0;
    icache_ready = 0;
    @(posedge clk);
    #2;
    chk("progress", 32'(pops > 100), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
